input_fifo: RTL and testbench

Per-port input buffer of the NoC router. It sits directly downstream of a neighbouring router's (or NI's) output buffer and accepts one flit per cycle on `valid_in`. It stores up to DEPTH flits in a circular first-word-fall-through FIFO and presents the head flit to the routing and crossbar logic, which pops it with `read_en`. `ready_out` flows back upstream as the flow-control signal that drives the output buffer's `enable`.

---
 rtl/input_fifo_pkg.sv | 26 ++
 rtl/input_fifo_if.sv | 28 ++
 rtl/fifo_regfile.sv | 24 ++
 rtl/input_fifo.sv | 80 ++++++++
 tb/tb_input_fifo.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/input_fifo_pkg.sv
// rtl/input_fifo_pkg.sv - shared sizes, types and occupancy helper for the router input FIFO
package input_fifo_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;
    localparam int PTR_WIDTH  = 2;

    typedef logic [DATA_WIDTH-1:0] flit_t;
    typedef logic [PTR_WIDTH-1:0]  ptr_t;
    typedef logic [PTR_WIDTH:0]    cnt_t;

    localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

    // Occupancy after one edge: +1 on accepted write, -1 on accepted read.
    function automatic cnt_t next_count(cnt_t cur, logic wr_acc, logic rd_acc);
        cnt_t nxt;
        nxt = cur;
        if (wr_acc && !rd_acc) begin
            nxt = cur + cnt_t'(1);
        end else if (rd_acc && !wr_acc) begin
            nxt = cur - cnt_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/input_fifo_if.sv
// rtl/input_fifo_if.sv - flit write, pop and status bundle of the router input FIFO
interface input_fifo_if;
    import input_fifo_pkg::*;

    logic  valid_in;
    flit_t data_in;
    logic  read_en;
    flit_t data_out;
    logic  ready_out;
    logic  empty;
    logic  full;
    cnt_t  count;
    logic  overflow;
    logic  underflow;

    // Upstream writer plus routing/crossbar reader side.
    modport master (
        output valid_in, data_in, read_en,
        input  data_out, ready_out, empty, full, count, overflow, underflow
    );

    // The FIFO itself.
    modport slave (
        input  valid_in, data_in, read_en,
        output data_out, ready_out, empty, full, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module fifo_regfile
    import input_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  we_i,
    input  ptr_t  waddr_i,
    input  flit_t wdata_i,
    input  ptr_t  raddr_i,
    output flit_t rdata_o
);

    flit_t mem_q [DEPTH];

    // Storage is not reset; stale slots are masked by the empty decode upstream.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/input_fifo.sv
// rtl/input_fifo.sv - first-word-fall-through per-port input buffer of the NoC router
module input_fifo
    import input_fifo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input_fifo_if.slave fifo
);

    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    cnt_t  count_q, count_d;
    logic  overflow_q, overflow_d;
    logic  underflow_q, underflow_d;
    logic  empty_w, full_w;
    logic  wr_acc, rd_acc;
    flit_t head_w;

    // Status decodes only from registered occupancy, never from same-cycle inputs.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_COUNT);
    assign wr_acc  = fifo.valid_in & ~full_w;
    assign rd_acc  = fifo.read_en & ~empty_w;

    // Pointer, occupancy and sticky error next-state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        count_d     = next_count(count_q, wr_acc, rd_acc);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        if (fifo.valid_in && full_w) begin
            overflow_d = 1'b1;
        end
        if (fifo.read_en && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    // State registers; reset clears everything at once, discarding queued flits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_regfile u_regfile (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (fifo.data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_w)
    );

    assign fifo.data_out  = empty_w ? '0 : head_w;
    assign fifo.empty     = empty_w;
    assign fifo.full      = full_w;
    assign fifo.ready_out = ~full_w;
    assign fifo.count     = count_q;
    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;

endmodule

// File: tb/tb_input_fifo.sv
// tb/tb_input_fifo.sv - directed vector bench for input_fifo
module tb_input_fifo;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic [31:0] exp_d;
        int          exp_cnt;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    vec_t vecs[$];

    input_fifo_if bus();

    input_fifo dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [31:0] d, logic r, logic [31:0] exp_d,
                                int exp_cnt, logic exp_ovf, logic exp_unf);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.exp_d = exp_d;
        t.exp_cnt = exp_cnt; t.exp_ovf = exp_ovf; t.exp_unf = exp_unf;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(string tag, logic [31:0] exp_d, int exp_cnt,
                             logic exp_ovf, logic exp_unf);
        chk({tag, ".data_out"},  bus.data_out, exp_d);
        chk({tag, ".count"},     32'(bus.count), 32'(exp_cnt));
        chk({tag, ".empty"},     32'(bus.empty), 32'(exp_cnt == 0));
        chk({tag, ".full"},      32'(bus.full), 32'(exp_cnt == 4));
        chk({tag, ".ready_out"}, 32'(bus.ready_out), 32'(exp_cnt != 4));
        chk({tag, ".overflow"},  32'(bus.overflow), 32'(exp_ovf));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(exp_unf));
    endtask

    task automatic step(logic v, logic [31:0] d, logic r);
        @(negedge clk);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.read_en  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.read_en  = 1'b0;
        rst = 1'b1;

        // fill
        vecs.push_back(mk(1, 32'hA0, 0, 32'hA0, 1, 0, 0));
        vecs.push_back(mk(1, 32'hA1, 0, 32'hA0, 2, 0, 0));
        vecs.push_back(mk(1, 32'hA2, 0, 32'hA0, 3, 0, 0));
        vecs.push_back(mk(1, 32'hA3, 0, 32'hA0, 4, 0, 0));
        // drain
        vecs.push_back(mk(0, 32'h0, 1, 32'hA1, 3, 0, 0));
        vecs.push_back(mk(0, 32'h0, 1, 32'hA2, 2, 0, 0));
        vecs.push_back(mk(0, 32'h0, 1, 32'hA3, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0, 1, 32'h0,  0, 0, 0));
        // bring to count 2
        vecs.push_back(mk(1, 32'hC0, 0, 32'hC0, 1, 0, 0));
        vecs.push_back(mk(1, 32'hC1, 0, 32'hC0, 2, 0, 0));
        // concurrent read+write, pointers wrap
        vecs.push_back(mk(1, 32'hB0, 1, 32'hC1, 2, 0, 0));
        vecs.push_back(mk(1, 32'hB1, 1, 32'hB0, 2, 0, 0));
        vecs.push_back(mk(1, 32'hB2, 1, 32'hB1, 2, 0, 0));
        vecs.push_back(mk(1, 32'hB3, 1, 32'hB2, 2, 0, 0));
        vecs.push_back(mk(1, 32'hB4, 1, 32'hB3, 2, 0, 0));
        vecs.push_back(mk(1, 32'hB5, 1, 32'hB4, 2, 0, 0));
        // fill to full
        vecs.push_back(mk(1, 32'hB6, 0, 32'hB4, 3, 0, 0));
        vecs.push_back(mk(1, 32'hB7, 0, 32'hB4, 4, 0, 0));
        // write while full: dropped; with a pop the pop still happens
        vecs.push_back(mk(1, 32'hDEAD, 0, 32'hB4, 4, 1, 0));
        vecs.push_back(mk(1, 32'hDEAD, 1, 32'hB5, 3, 1, 0));
        vecs.push_back(mk(0, 32'h0, 1, 32'hB6, 2, 1, 0));
        vecs.push_back(mk(0, 32'h0, 1, 32'hB7, 1, 1, 0));
        vecs.push_back(mk(0, 32'h0, 1, 32'h0,  0, 1, 0));
        // read while empty with a concurrent write
        vecs.push_back(mk(1, 32'h55, 1, 32'h55, 1, 1, 1));
        vecs.push_back(mk(0, 32'h0, 1, 32'h0,  0, 1, 1));

        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 32'h0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].d, vecs[i].r);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_cnt,
                      vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // mid-operation asynchronous reset at count 3
        step(1, 32'h11, 0);
        step(1, 32'h22, 0);
        step(1, 32'h33, 0);
        chk_state("pre_rst", 32'h11, 3, 1, 1);
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.read_en  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 32'h0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 32'h77, 0);
        chk_state("post_rst", 32'h77, 1, 0, 0);
        step(0, 32'h0, 1);
        chk_state("post_rst_pop", 32'h0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
